// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction loader and the core's hazard unit.
package imem_loader_pkg;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // A requested length of zero, or one beyond the RAM, means "fill the whole RAM".
    function automatic logic [6:0] clamp_len(input logic [6:0] req, input int unsigned depth);
        if (req == '0 || 32'(req) > depth) begin
            return 7'(depth);
        end
        return req;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream load port, status outputs and IF-stage fetch port of imem_loader.
interface imem_loader_if;

    logic        load_start;
    logic [6:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        cpu_hold;
    logic        load_busy;
    logic        load_done;
    logic [6:0]  word_count;
    logic [31:0] pc;
    logic [31:0] inst;

    modport master (
        output load_start, load_len, byte_valid, byte_data, pc,
        input  byte_ready, cpu_hold, load_busy, load_done, word_count, inst
    );

    modport slave (
        input  load_start, load_len, byte_valid, byte_data, pc,
        output byte_ready, cpu_hold, load_busy, load_done, word_count, inst
    );

endinterface

// File: rtl/imem_loader_ram.sv
// Instruction RAM: synchronous write, asynchronous read; contents survive reset.
module imem_ram #(
    parameter int unsigned DEPTH = imem_loader_pkg::DEPTH,
    parameter int unsigned AW    = imem_loader_pkg::AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream into the
// instruction RAM while stalling the core, then serves IF-stage fetches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = imem_loader_pkg::DEPTH,
    parameter int unsigned AW    = imem_loader_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus
);

    load_state_t   state, state_next;
    logic [6:0]    len;
    logic [AW-1:0] word_ptr;
    logic [1:0]    byte_idx;
    logic [6:0]    word_count;
    logic [23:0]   shift;

    logic          accept;
    logic          word_we;
    logic          last_word;
    logic          byte_ready, cpu_hold, load_busy, load_done;
    logic          unused_pc_bits;

    assign accept    = (state == LOAD) && bus.byte_valid;
    assign word_we   = accept && (byte_idx == 2'd3);
    assign last_word = (word_count == len - 7'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            word_ptr   <= '0;
            byte_idx   <= '0;
            word_count <= '0;
            shift      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.load_start) begin
                len        <= clamp_len(bus.load_len, DEPTH);
                word_ptr   <= '0;
                byte_idx   <= '0;
                word_count <= '0;
            end else if (accept) begin
                if (byte_idx == 2'd3) begin
                    word_ptr   <= word_ptr + AW'(1);
                    word_count <= word_count + 7'd1;
                    byte_idx   <= '0;
                end else begin
                    shift[8*byte_idx +: 8] <= bus.byte_data;
                    byte_idx               <= byte_idx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                load_busy  = 1'b1;
                if (word_we && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_hold   = 1'b1;
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The final byte goes straight to the RAM with the three buffered ones.
    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (word_we),
        .waddr (word_ptr),
        .wdata ({bus.byte_data, shift}),
        .raddr (bus.pc[AW+1:2]),
        .rdata (bus.inst)
    );

    assign unused_pc_bits = ^{bus.pc[31:AW+2], bus.pc[1:0]};

    assign bus.byte_ready = byte_ready;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.load_busy  = load_busy;
    assign bus.load_done  = load_done;
    assign bus.word_count = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations, a monitor checks them.
module tb_imem_loader;

    typedef enum int { K_INST, K_WC, K_HOLD, K_READY, K_BUSY } kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] exp;
    } probe_t;

    typedef struct {
        logic [6:0] wc;
        int         nbytes;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic probe = 1'b0;

    int checks = 0;
    int errors = 0;
    int nbytes = 0;
    int hold_run = 0;

    probe_t probe_q[$];
    done_t  done_q[$];
    int     hold_q[$];

    logic [31:0] model [64];

    imem_loader_if bus();

    imem_loader #(
        .DEPTH (64),
        .AW    (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            nbytes = 0;
        end else begin
            if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) nbytes++;
            if (bus.load_done !== 1'b0) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: load_done=%b with no load pending", bus.load_done);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    if (bus.word_count !== d.wc || nbytes != d.nbytes) begin
                        errors++;
                        $display("FAIL done_event: word_count=%0d bytes=%0d, expected word_count=%0d bytes=%0d",
                                 bus.word_count, nbytes, d.wc, d.nbytes);
                    end
                end
                nbytes = 0;
            end
        end

        if (bus.cpu_hold === 1'b1) begin
            hold_run++;
        end else if (hold_run > 0) begin
            checks++;
            if (hold_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hold: cpu_hold ran %0d cycles with none expected", hold_run);
            end else begin
                int e;
                e = hold_q.pop_front();
                if (e >= 0 && e != hold_run) begin
                    errors++;
                    $display("FAIL hold_length: got %0d cycles, expected %0d", hold_run, e);
                end
            end
            hold_run = 0;
        end

        if (probe) begin
            while (probe_q.size() > 0) begin
                probe_t p;
                logic [31:0] got;
                p = probe_q.pop_front();
                case (p.kind)
                    K_INST:  got = bus.inst;
                    K_WC:    got = {25'b0, bus.word_count};
                    K_HOLD:  got = {31'b0, bus.cpu_hold};
                    K_READY: got = {31'b0, bus.byte_ready};
                    default: got = {31'b0, bus.load_busy};
                endcase
                checks++;
                if (got !== p.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", p.name, got, p.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input kind_t kind, input logic [31:0] exp);
        probe_t p;
        p.name = name;
        p.kind = kind;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic expect_done(input logic [6:0] wc, input int nb);
        done_t d;
        d.wc     = wc;
        d.nbytes = nb;
        done_q.push_back(d);
    endtask

    task automatic sample();
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic check_inst(input string name, input logic [31:0] pc, input logic [31:0] exp);
        bus.pc = pc;
        expect_val(name, K_INST, exp);
        sample();
    endtask

    task automatic start_load(input logic [6:0] len);
        bus.load_len   = len;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   t;
        bus.byte_valid = 1'b0;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        acc = 1'b0;
        t   = 0;
        do begin
            @(negedge clk);
            acc = bus.byte_ready;
            @(posedge clk);
            #1;
            t++;
        end while (acc !== 1'b1 && t < 200);
        bus.byte_valid = 1'b0;
        if (acc !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h not accepted after %0d cycles", b, t);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    function automatic logic [7:0] fill_byte(input int j);
        return 8'((j * 37 + 5) & 255);
    endfunction

    initial begin
        logic [31:0] w [3];
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.pc         = '0;

        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        expect_val("rst_byte_ready", K_READY, 32'd0);
        expect_val("rst_cpu_hold",   K_HOLD,  32'd0);
        expect_val("rst_load_busy",  K_BUSY,  32'd0);
        expect_val("rst_word_count", K_WC,    32'd0);
        sample();

        // Full-depth load via load_len=0
        for (int i = 0; i < 64; i++) begin
            model[i] = {fill_byte(4*i+3), fill_byte(4*i+2), fill_byte(4*i+1), fill_byte(4*i)};
        end
        expect_done(7'd64, 256);
        hold_q.push_back(257);
        start_load(7'd0);
        for (int i = 0; i < 64; i++) send_word(model[i], 0);
        tick();
        expect_val("full_word_count", K_WC, 32'd64);
        sample();
        check_inst("full_pc_0",    32'h0000_0000, model[0]);
        check_inst("full_pc_80",   32'h0000_0080, model[32]);
        check_inst("full_pc_100",  32'h0000_0100, model[0]);
        check_inst("full_pc_0fe",  32'h0000_00FE, model[63]);
        check_inst("full_pc_hi",   32'hFFFF_FF0C, model[3]);

        // Single word, no gaps, with same-cycle read of the address being written
        expect_done(7'd1, 4);
        hold_q.push_back(5);
        bus.pc = 32'h0;
        start_load(7'd1);
        expect_val("one_busy",  K_BUSY,  32'd1);
        expect_val("one_hold",  K_HOLD,  32'd1);
        expect_val("one_ready", K_READY, 32'd1);
        probe = 1'b1;
        send_byte(8'h93, 0);
        probe = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        expect_val("one_same_cycle_old", K_INST, model[0]);
        probe = 1'b1;
        send_byte(8'h00, 0);
        probe = 1'b0;
        model[0] = 32'h0010_0093;
        expect_val("one_next_cycle_new", K_INST, 32'h0010_0093);
        sample();
        expect_val("one_idle_hold", K_HOLD, 32'd0);
        expect_val("one_idle_busy", K_BUSY, 32'd0);
        expect_val("one_word_count", K_WC,  32'd1);
        sample();

        // Three words with random byte_valid gaps
        w[0] = 32'hDEAD_BEEF;
        w[1] = 32'h1234_5678;
        w[2] = 32'hCAFE_F00D;
        expect_done(7'd3, 12);
        hold_q.push_back(-1);
        start_load(7'd3);
        for (int i = 0; i < 3; i++) begin
            send_word(w[i], 3);
            model[i] = w[i];
        end
        tick();
        expect_val("three_word_count", K_WC, 32'd3);
        sample();
        check_inst("three_pc_0", 32'h0, model[0]);
        check_inst("three_pc_4", 32'h4, model[1]);
        check_inst("three_pc_8", 32'h8, model[2]);
        check_inst("three_pc_c_unchanged", 32'hC, model[3]);

        // Reset after 6 bytes of a 2-word load; the 7th byte meets the reset edge
        hold_q.push_back(7);
        start_load(7'd2);
        send_word(32'h0BAD_C0DE, 0);
        send_byte(8'hCC, 0);
        send_byte(8'h33, 0);
        rst = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        tick();
        rst = 1'b0;
        model[0] = 32'h0BAD_C0DE;
        expect_val("rst_mid_ready", K_READY, 32'd0);
        expect_val("rst_mid_hold",  K_HOLD,  32'd0);
        expect_val("rst_mid_busy",  K_BUSY,  32'd0);
        expect_val("rst_mid_wc",    K_WC,    32'd0);
        sample();
        bus.byte_valid = 1'b0;
        check_inst("rst_mid_word0", 32'h0, model[0]);
        check_inst("rst_mid_word1", 32'h4, model[1]);

        // load_start re-pulsed during LOAD and DONE must be ignored
        expect_done(7'd2, 8);
        hold_q.push_back(9);
        start_load(7'd2);
        bus.load_len = 7'd5;
        send_byte(8'h04, 0);
        send_byte(8'h03, 0);
        bus.load_start = 1'b1;
        send_byte(8'h02, 0);
        bus.load_start = 1'b0;
        send_byte(8'h01, 0);
        send_word(32'h0A0B_0C0D, 0);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        model[0] = 32'h0102_0304;
        model[1] = 32'h0A0B_0C0D;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        expect_val("restart_ready", K_READY, 32'd0);
        expect_val("restart_busy",  K_BUSY,  32'd0);
        expect_val("restart_wc",    K_WC,    32'd2);
        sample();

        // Bytes offered in IDLE without load_start
        for (int i = 0; i < 3; i++) begin
            bus.byte_data = 8'(8'hF0 + i);
            expect_val("idle_ready", K_READY, 32'd0);
            expect_val("idle_hold",  K_HOLD,  32'd0);
            sample();
        end
        bus.byte_valid = 1'b0;
        check_inst("idle_pc_0", 32'h0, model[0]);
        check_inst("idle_pc_4", 32'h4, model[1]);
        check_inst("idle_pc_8", 32'h8, model[2]);
        expect_val("idle_wc", K_WC, 32'd2);
        sample();

        repeat (4) tick();
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d load_done pulses outstanding, expected 0", done_q.size());
        end
        checks++;
        if (hold_q.size() != 0) begin
            errors++;
            $display("FAIL missing_hold: %0d cpu_hold windows outstanding, expected 0", hold_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader and fetch port for the pipelined RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. The words are written into a 64-word instruction RAM, and the core is held stalled until the program is complete. After loading, it serves the IF stage with a combinational read indexed by pc[7:2].

## Interface
Parameters:
- DEPTH, 64, number of 32-bit instruction words
- AW, 6, word-address width (log2 DEPTH)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle request to begin a load; sampled only in IDLE
- load_len  in  7  words to load, sampled with load_start; 0 means DEPTH, values >DEPTH clamp to DEPTH
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  program byte, least-significant byte of each word first
- byte_ready  out  1  loader accepts a byte this cycle
- cpu_hold  out  1  stall or flush request to the core; high while loading
- load_busy  out  1  high in LOAD
- load_done  out  1  one-cycle pulse when the final word is written
- word_count  out  7  words written in the current or last load
- pc  in  32  IF-stage program counter
- inst  out  32  instruction at pc[7:2]

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - load_start=1 → LOAD.
  - Latch len = (load_len==0 || load_len>DEPTH) ? DEPTH : load_len.
  - Clear word_ptr, byte_idx and word_count.
- LOAD:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte k of a word (k = byte_idx 0..3) goes into bits [8k+7:8k] of the shift register.
  - On acceptance with byte_idx==3, write {byte_data, shift[23:0]} to RAM[word_ptr], increment word_ptr and word_count, and clear byte_idx.
  - If that write is word len-1 → DONE.
- DONE: lasts one cycle; load_done=1 and cpu_hold=1; then → IDLE.
- Outputs by state:
  - cpu_hold=1 in LOAD and DONE, 0 in IDLE.
  - load_busy=1 only in LOAD.
- load_start in LOAD or DONE is ignored.
- Bytes presented outside LOAD are not accepted (byte_ready=0) and produce no effect.
- Fetch: inst = RAM[pc[7:2]], combinational in every state. pc[1:0] and pc[31:8] are ignored, so addresses wrap modulo 256 bytes.
- RAM contents are not cleared by rst.
- Words outside 0..len-1 keep their previous contents.

## Timing
- Reset values:
  - state=IDLE
  - byte_ready=0, cpu_hold=0, load_busy=0, load_done=0
  - word_count=0, byte_idx=0, word_ptr=0
  - inst reflects the RAM (not reset).
- load_start at edge E0 → LOAD from E0; byte_ready=1 in the cycle after E0.
- Each word needs 4 accepted bytes. Gaps in byte_valid stall the assembly with no timeout.
- The RAM write commits at the edge that accepts byte 3.
  - A same-cycle read of that address returns the old word.
  - The new word is visible on inst in the following cycle.
- N words with no valid gaps: LOAD lasts 4N cycles, then DONE for 1 cycle. cpu_hold falls 4N+1 cycles after the first byte_ready cycle.
- rst mid-load:
  - Next state is IDLE and the partial word is discarded.
  - Already-written words are retained.
  - cpu_hold drops the cycle after reset.
- rst has priority over load_start and byte acceptance in the same cycle.

## Structure
- Shared package: the state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and the DEPTH/AW defaults, shared with the core's hazard unit, which consumes cpu_hold.
- Sub-module imem_ram:
  - DEPTH×32 array.
  - Synchronous write port: we, waddr[AW-1:0], wdata[31:0].
  - Asynchronous read port: raddr = pc[7:2].
- FSM, byte assembler and counters sit in imem_loader.

## Test plan
- Load 1 word, bytes 0x93 0x00 0x10 0x00 with no gaps → RAM[0]=0x00100093, load_done pulses exactly once, cpu_hold high for 5 cycles, then inst=0x00100093 at pc=0x0.
- Load 3 words with random 0–3 cycle byte_valid gaps → word_count=3, RAM[0..2] correct, RAM[3] unchanged, inst at pc=0x8 equals word 2.
- load_len=0 with 256 bytes → 64 words written, word_count=64, pc=0x100 returns RAM[0] (wrap), pc=0x0FE returns RAM[63].
- Assert rst after 6 bytes of a 2-word load → RAM[0] written, RAM[1] unchanged, state IDLE, cpu_hold=0, word_count=0, the 7th byte is not accepted.
- Pulse load_start again mid-load (len 2) → ignored; exactly 8 bytes consumed and one load_done.
- Present byte_valid in IDLE with no load_start → byte_ready=0, RAM unchanged, no load_done.
